// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size codes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Size 11 is treated the same as a misaligned access.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic r;
    r = 1'b0;
    case (size)
      SIZE_B:  r = 1'b0;
      SIZE_H:  r = off[0];
      SIZE_W:  r = |off;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for stores and extract/extend for loads.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_sh;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_wdata_i;
    case (st_size_i)
      SIZE_B: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_wdata_i[7:0]}};
      end
      SIZE_H: begin
        st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = {2{st_wdata_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
      end
    endcase
  end

  assign ld_sh = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = ld_sh;
    case (ld_size_i)
      SIZE_B: ld_data_o = ld_unsigned_i ?
                {24'b0, ld_sh[7:0]} :
                {{24{ld_sh[7]}}, ld_sh[7:0]};
      SIZE_H: ld_data_o = ld_unsigned_i ?
                {16'b0, ld_sh[15:0]} :
                {{16{ld_sh[15]}}, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: MEM stage to handshaked data memory bridge.
// Optional bus-error timeout in REQ enabled by LSU_TIMEOUT_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        misaligned_o,
  output logic        bus_error_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] ldata_q, ldata_d;
  logic        lvalid_q, lvalid_d;
  logic        mis_q, mis_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        bad;
  logic        accept;
  logic        timeout;

  lsu_align u_align (
    .st_off_i      (req_addr_i[1:0]),
    .st_size_i     (req_size_i),
    .st_wdata_i    (req_wdata_i),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .ld_off_i      (off_q),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_rdata_i    (mem_rdata_i),
    .ld_data_o     (ld_data)
  );

  assign bad     = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign accept  = (state_q == IDLE) && req_valid_i && !bad;
  assign stall_o = accept || (state_q == REQ);

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    berr_d = 1'b0;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == REQ && !mem_ready_i) begin
      cnt_d  = cnt_q + 1'b1;
      berr_d = timeout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      berr_q <= berr_d;
    end
  end

  assign bus_error_o = berr_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{TIMEOUT_CYCLES, CNT_W};
  assign timeout     = 1'b0;
  assign bus_error_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    ldata_d     = ldata_q;
    lvalid_d    = 1'b0;
    mis_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && bad) begin
          mis_d = 1'b1;
        end else if (accept) begin
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = req_we_i;
          mem_be_d    = st_be;
          mem_addr_d  = {req_addr_i[31:2], 2'b00};
          mem_wdata_d = st_wdata;
          off_d       = req_addr_i[1:0];
          size_d      = req_size_i;
          uns_d       = req_unsigned_i;
        end
      end
      REQ: begin
        if (mem_ready_i || timeout) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = '0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          lvalid_d    = !mem_we_q;
          if (!mem_ready_i) begin
            ldata_d = '0;
          end else if (!mem_we_q) begin
            ldata_d = ld_data;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      ldata_q     <= '0;
      lvalid_q    <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      ldata_q     <= ldata_d;
      lvalid_q    <= lvalid_d;
      mis_q       <= mis_d;
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign load_data_o  = ldata_q;
  assign load_valid_o = lvalid_q;
  assign misaligned_o = mis_q;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit between the core's MEM stage and a handshaked data memory. It converts a byte/half/word access into a word-aligned bus transaction with byte enables. It sign- or zero-extends load results and holds the pipeline with stall_o until the memory completes. It replaces the direct single-cycle coupling of the MEM stage to data memory, so the core can use memories that insert wait states.

Parameters:
TIMEOUT_CYCLES, 255, wait cycles in REQ before the bus-error abort (only with LSU_TIMEOUT_EN); range 1..65535
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid_i  in  1  MEM stage holds a load/store
req_we_i  in  1  1=store, 0=load
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  in  1  LBU/LHU zero-extend
req_addr_i  in  32  byte address (ALU result)
req_wdata_i  in  32  store data, unshifted rs2
stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
load_data_o  out  32  aligned, extended load result
load_valid_o  out  1  load_data_o valid (DONE, load)
misaligned_o  out  1  1-cycle pulse: misaligned or illegal size
bus_error_o  out  1  1-cycle pulse: timeout abort
mem_req_o  out  1  bus request, registered
mem_we_o  out  1  bus write
mem_be_o  out  4  byte enables
mem_addr_o  out  32  {req_addr[31:2],2'b00}
mem_wdata_o  out  32  lane-replicated store data
mem_ready_i  in  1  completes transaction; mem_rdata_i valid same cycle for reads
mem_rdata_i  in  32  read word

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state IDLE; all mem_* outputs 0; load_data_o 0; load_valid_o 0; misaligned_o 0; bus_error_o 0; counter 0.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11 is illegal.
- FSM IDLE:
  - req_valid_i and aligned: register addr, we, size, unsigned and the lane-formatted data/be; go to REQ.
  - stall_o = 1, combinational, in this cycle.
  - Misaligned or illegal: misaligned_o pulses next cycle, no bus access, no stall, stay IDLE.
- FSM REQ: mem_req_o = 1, with addr/we/be/wdata stable, until mem_ready_i is sampled high.
  - On ready, capture the extracted load data and go to DONE.
  - stall_o = 1 throughout.
- FSM DONE: stall_o = 0, load_valid_o = 1 if load, pipeline advances.
  - Always go to IDLE; req_valid_i is ignored in DONE because it is the same instruction.
- Minimum latency with ready in the first REQ cycle: 3 cycles (IDLE, REQ, DONE); the stall lasts 2 cycles.
- Store lanes:
  - byte: be = 4'b0001<<addr[1:0], wdata = {4{wd[7:0]}}
  - half: be = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}
  - word: be = 1111, wdata unchanged
- Loads:
  - mem_be_o follows the same rule as stores.
  - Data = rdata>>(8*addr[1:0]), truncated to the access size, then sign-extended unless req_unsigned_i.
  - load_data_o holds its value until the next capture.
- mem_* outputs return to 0 in the cycle after ready.
- rst asserted in any state: IDLE next edge, mem_req_o low next cycle, in-flight result discarded, no pulses.
- mem_ready_i outside REQ is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: the counter increments every REQ cycle without ready. When it reaches TIMEOUT_CYCLES without ready:
  - bus_error_o pulses and mem_req_o drops
  - load_data_o = 0
  - go to DONE
- The counter clears on entering REQ.
- Undefined: REQ waits indefinitely, bus_error_o tied 0, no counter logic.

Decomposition:
- Package lsu_pkg: size encodings (SIZE_B/H/W), FSM state enum (IDLE/REQ/DONE).
- Sub-module lsu_align (combinational): store lane/be generation and load extract/extend.
- lsu contains only the FSM, registers and timeout.

Test Plan:
1. SW addr 0x104, wd 0xDEADBEEF, ready on first REQ cycle -> mem_addr 0x104, be 1111, wdata 0xDEADBEEF; stall_o high 2 cycles, low in DONE.
2. LB addr 0x203, rdata 0x80FF_0000, signed -> load_data 0xFFFFFF80; LBU -> 0x00000080; be 1000.
3. LH addr 0x302, rdata 0x8001_1234 -> 0xFFFF8001; SH addr 0x302, wd 0x0000ABCD -> be 1100, wdata 0xABCDABCD.
4. LW addr 0x101 -> misaligned_o pulse, mem_req_o never high, stall_o 0; size 11 -> same.
5. Ready delayed 5 cycles -> mem_req_o/addr stable 5 REQ cycles, stall 6 cycles; rst in 3rd REQ cycle -> IDLE, no load_valid_o.
6. LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never -> bus_error_o pulse after 4 REQ cycles, load_data 0, then IDLE.
